vram_write_queue: RTL and testbench
===================================

// Module: vram_write_queue
// PURPOSE
//  Sits directly downstream of the CDM16 wrapper's video port (vram_addr/vram_data/vram_wr).
//  Buffers CPU-originated VRAM writes in a small FIFO and drains them into the single-port
//  framebuffer RAM, arbitrating against scanout read requests.
//  Scanout normally has priority; a flush mode gives the write queue priority until it is empty.
// PARAMETERS
//  ADDR_W      16  VRAM word address width
//  DATA_W      16  VRAM data width
//  FIFO_DEPTH  8   write queue entries; power of 2, >= 2
// PORTS
//  clock        in   1           single system clock, all logic on rising edge
//  reset        in   1           synchronous, active-high
//  wr_en        in   1           CPU-side write strobe (from vram_wr), one entry per cycle high
//  wr_addr      in   ADDR_W      CPU-side write address
//  wr_data      in   DATA_W      CPU-side write data
//  flush_req    in   1           pulse: enter FLUSH mode
//  flush_done   out  1           1-cycle pulse when FLUSH completes
//  rd_req       in   1           scanout read request
//  rd_addr      in   ADDR_W      scanout read address
//  rd_grant     out  1           rd_req accepted this cycle
//  rd_valid     out  1           rd_data valid; exactly 1 cycle after rd_grant
//  rd_data      out  DATA_W      scanout read data (vram_rdata passthrough)
//  vram_en      out  1           RAM access this cycle
//  vram_we      out  1           1 = write, 0 = read (meaningful only when vram_en)
//  vram_addr    out  ADDR_W      RAM address
//  vram_wdata   out  DATA_W      RAM write data
//  vram_rdata   in   DATA_W      RAM read data, sync RAM, valid 1 cycle after read
//  fifo_level   out  clog2(D)+1  current entry count, 0..FIFO_DEPTH
//  fifo_full    out  1           fifo_level == FIFO_DEPTH
//  overflow     out  1           sticky: a write was dropped since reset
//  drop_count   out  8           dropped-write count, saturates at 255
// BEHAVIOUR
//  Reset: FIFO empty, state NORMAL, all outputs 0 (fifo_level 0, rd_valid 0, overflow 0,
//   drop_count 0, flush_done 0, vram_en/we 0). Reset mid-operation discards queued writes and
//   any pending rd_valid.
//  FIFO: registered storage, separate rd/wr pointers, wrap modulo FIFO_DEPTH.
//   push = wr_en && (!full || pop). Full + wr_en + pop same cycle: accepted, level unchanged.
//   wr_en while full and no pop: entry dropped, overflow <= 1, drop_count++ (saturating).
//   fifo_level updates the cycle after push/pop; it is never decremented below 0.
//  Arbitration, combinational each cycle (no idle cycle between accesses):
//   NORMAL: rd_req -> rd_grant=1, vram_en=1, we=0, addr=rd_addr, no pop.
//     else FIFO non-empty -> vram_en=1, we=1, addr/wdata=head entry, pop.
//     else vram_en=0.
//   FLUSH: FIFO non-empty -> write head, pop; rd_grant=0 even if rd_req.
//     FIFO empty -> reads granted as in NORMAL.
//  States:
//   NORMAL -> FLUSH on flush_req.
//   FLUSH -> NORMAL the cycle after the last pop, or immediately if empty at entry;
//     flush_done pulses on that transition.
//   flush_req while in FLUSH: ignored.
//   Writes pushed during FLUSH are drained before exit.
//  Write latency: wr_en at cycle N into empty FIFO, no rd_req -> vram_we at N+1 (earliest).
//  Read latency: rd_grant at N -> rd_valid=1 at N+1, rd_data=vram_rdata.
//   Back-to-back grants give back-to-back rd_valid.
//  Ordering: writes reach RAM in push order. No read-after-write forwarding: a scanout read of
//   an address still queued returns the old RAM contents (accepted display tearing).
//  A push and a pop of the same entry never happen in the same cycle; an entry is visible
//   at the head one cycle after push.
// TESTING
//  1 Reset, wr_en 1 cycle (addr 0x0040, data 0xBEEF), rd_req=0
//    -> cycle+1: vram_en=1, we=1, addr 0x0040, wdata 0xBEEF; level returns to 0.
//  2 Push 3 writes while rd_req held high 5 cycles
//    -> no vram_we during rd_req, rd_valid trails each grant by 1; then 3 writes in push order.
//  3 rd_req held high, 10 pushes (DEPTH 8)
//    -> fifo_full after 8, drop_count=2, overflow=1; after rd_req drops, exactly 8 writes.
//  4 5 entries queued, rd_req high, pulse flush_req
//    -> rd_grant=0 for 5 write cycles, flush_done 1 cycle after last pop, then reads resume.
//  5 Full FIFO, rd_req=0, wr_en same cycle as pop -> accepted, level stays 8, drop_count unchanged.
//  6 Reset asserted with 4 entries queued and a read in flight
//    -> next cycle level 0, rd_valid 0, no vram_we until new push.

Source files
------------

// File: rtl/vram_write_queue.sv
// vram_write_queue
// Buffers CPU-side VRAM writes in a small FIFO and drains them into a
// single-port framebuffer RAM. Scanout reads normally win arbitration; a
// flush request gives the queue priority until it has fully drained.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_NORMAL| scanout reads have priority, queue drains in idle cycles
// ST_FLUSH | queue has priority, reads granted only once the queue is empty
module vram_write_queue #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_wr_en,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W-1:0]             i_wr_data,
    input  logic                          i_flush_req,
    output logic                          o_flush_done,
    input  logic                          i_rd_req,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    output logic                          o_rd_grant,
    output logic                          o_rd_valid,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_vram_en,
    output logic                          o_vram_we,
    output logic [ADDR_W-1:0]             o_vram_addr,
    output logic [DATA_W-1:0]             o_vram_wdata,
    input  logic [DATA_W-1:0]             i_vram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_fifo_full,
    output logic                          o_overflow,
    output logic [7:0]                    o_drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_flush_done;
    logic               r_rd_valid;
    logic               r_overflow;
    logic [7:0]         r_drop_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [ADDR_W-1:0]  r_mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_mem_data [FIFO_DEPTH];

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_grant;
    logic               w_en;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic [LVL_W-1:0]   w_level_next;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);

    // Arbitration between the queue head and scanout; no idle cycle between accesses.
    // Held quiet while reset is asserted so the RAM sees no stray access.
    always_comb begin
        w_grant = 1'b0;
        w_pop   = 1'b0;
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (!i_reset) begin
            if (r_state == ST_FLUSH && !w_empty) begin
                w_en    = 1'b1;
                w_we    = 1'b1;
                w_addr  = r_mem_addr[r_rd_ptr];
                w_wdata = r_mem_data[r_rd_ptr];
                w_pop   = 1'b1;
            end else if (i_rd_req) begin
                w_grant = 1'b1;
                w_en    = 1'b1;
                w_addr  = i_rd_addr;
            end else if (!w_empty) begin
                w_en    = 1'b1;
                w_we    = 1'b1;
                w_addr  = r_mem_addr[r_rd_ptr];
                w_wdata = r_mem_data[r_rd_ptr];
                w_pop   = 1'b1;
            end
        end
    end

    // A full queue still accepts a write when the head is leaving the same cycle.
    assign w_push = i_wr_en && (!w_full || w_pop);
    assign w_drop = i_wr_en && w_full && !w_pop;

    // Next entry count; pop is only ever issued on a non-empty queue.
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - 1'b1;
        end
    end

    // Queue payload storage; contents need no reset since level gates visibility.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= i_wr_addr;
            r_mem_data[r_wr_ptr] <= i_wr_data;
        end
    end

    // Queue pointers, level and drop accounting.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    // Read data is valid the cycle after a grant, matching the sync RAM latency.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_grant;
        end
    end

    // Mode FSM: flush holds until the queue is seen empty, then pulses flush_done.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_NORMAL;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                ST_NORMAL: begin
                    if (i_flush_req) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_level_next == '0) begin
                        r_state      <= ST_NORMAL;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= ST_NORMAL;
            endcase
        end
    end

    assign o_flush_done = r_flush_done;
    assign o_rd_grant   = w_grant;
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_valid ? i_vram_rdata : '0;
    assign o_vram_en    = w_en;
    assign o_vram_we    = w_we;
    assign o_vram_addr  = w_addr;
    assign o_vram_wdata = w_wdata;
    assign o_fifo_level = r_level;
    assign o_fifo_full  = w_full;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue with a behavioural sync RAM.
module tb_vram_write_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        flush_req;
    logic        flush_done;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_grant;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        vram_en;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [15:0] vram_wdata;
    logic [15:0] vram_rdata;
    logic [3:0]  fifo_level;
    logic        fifo_full;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] ram [0:65535];

    always #5 clock = ~clock;

    vram_write_queue #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(8)) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_flush_req  (flush_req),
        .o_flush_done (flush_done),
        .i_rd_req     (rd_req),
        .i_rd_addr    (rd_addr),
        .o_rd_grant   (rd_grant),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_vram_en    (vram_en),
        .o_vram_we    (vram_we),
        .o_vram_addr  (vram_addr),
        .o_vram_wdata (vram_wdata),
        .i_vram_rdata (vram_rdata),
        .o_fifo_level (fifo_level),
        .o_fifo_full  (fifo_full),
        .o_overflow   (overflow),
        .o_drop_count (drop_count)
    );

    // Single-port synchronous RAM model.
    always @(posedge clock) begin
        if (vram_en && vram_we) ram[vram_addr] <= vram_wdata;
        if (vram_en && !vram_we) vram_rdata <= ram[vram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic chk_write(input string tag, input logic [15:0] a, input logic [15:0] d);
        chk({tag, "_en"}, vram_en, 1);
        chk({tag, "_we"}, vram_we, 1);
        chk({tag, "_addr"}, vram_addr, a);
        chk({tag, "_wdata"}, vram_wdata, d);
    endtask

    initial begin
        reset = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
        flush_req = 0; rd_req = 0; rd_addr = 0; vram_rdata = 0;
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        cyc(); cyc();
        mid();
        chk("rst_level", fifo_level, 0);
        chk("rst_en", vram_en, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_full", fifo_full, 0);

        // Single write into an empty queue
        cyc(); reset = 0;
        wr_en = 1; wr_addr = 16'h0040; wr_data = 16'hBEEF;
        mid(); chk("t1_no_same_cycle", vram_en, 0);
        cyc(); wr_en = 0;
        mid();
        chk_write("t1_wr", 16'h0040, 16'hBEEF);
        chk("t1_level1", fifo_level, 1);
        cyc();
        mid();
        chk("t1_level0", fifo_level, 0);
        chk("t1_idle", vram_en, 0);
        chk("t1_ram", ram[16'h0040], 16'hBEEF);

        // Reads have priority over queued writes
        for (int i = 0; i < 5; i++) begin
            cyc();
            rd_req = 1; rd_addr = 16'h0040;
            wr_en = (i < 3); wr_addr = 16'h0100 + 16'(i); wr_data = 16'h1000 + 16'(i);
            mid();
            chk("t2_grant", rd_grant, 1);
            chk("t2_we", vram_we, 0);
            chk("t2_rd_valid", rd_valid, (i != 0));
            if (i != 0) chk("t2_rd_data", rd_data, 16'hBEEF);
        end
        cyc(); rd_req = 0; wr_en = 0;
        mid();
        chk("t2_last_valid", rd_valid, 1);
        chk_write("t2_w0", 16'h0100, 16'h1000);
        for (int i = 1; i < 3; i++) begin
            cyc(); mid();
            chk_write("t2_wn", 16'h0100 + 16'(i), 16'h1000 + 16'(i));
        end
        cyc(); mid();
        chk("t2_done_en", vram_en, 0);
        chk("t2_done_valid", rd_valid, 0);

        // Overflow: 10 pushes while reads hold the port
        for (int i = 0; i < 10; i++) begin
            cyc();
            rd_req = 1; wr_en = 1;
            wr_addr = 16'h0200 + 16'(i); wr_data = 16'h2000 + 16'(i);
            mid();
            chk("t3_level", fifo_level, i > 8 ? 8 : i);
            chk("t3_full", fifo_full, (i >= 8));
        end
        cyc(); wr_en = 0;
        mid();
        chk("t3_drop", drop_count, 2);
        chk("t3_overflow", overflow, 1);
        chk("t3_level8", fifo_level, 8);
        for (int i = 0; i < 8; i++) begin
            cyc(); rd_req = 0; mid();
            chk_write("t3_drain", 16'h0200 + 16'(i), 16'h2000 + 16'(i));
        end
        cyc(); mid();
        chk("t3_drained", vram_en, 0);
        chk("t3_level0", fifo_level, 0);

        // Full queue, push coincident with pop
        for (int i = 0; i < 8; i++) begin
            cyc();
            rd_req = 1; wr_en = 1;
            wr_addr = 16'h0300 + 16'(i); wr_data = 16'h3000 + 16'(i);
        end
        cyc(); rd_req = 0; wr_en = 1; wr_addr = 16'h03AA; wr_data = 16'h3AAA;
        mid();
        chk("t5_full", fifo_full, 1);
        chk_write("t5_pop", 16'h0300, 16'h3000);
        cyc(); wr_en = 0; rd_req = 1;
        mid();
        chk("t5_level", fifo_level, 8);
        chk("t5_drop", drop_count, 2);

        // Drain down to 4 entries, then reset with a read in flight
        for (int i = 1; i < 5; i++) begin
            cyc(); rd_req = 0; mid();
            chk_write("t6_drain", 16'h0300 + 16'(i), 16'h3000 + 16'(i));
        end
        cyc(); rd_req = 1; mid();
        chk("t6_level4", fifo_level, 4);
        chk("t6_grant", rd_grant, 1);
        cyc(); rd_req = 0; reset = 1;
        cyc(); reset = 0;
        mid();
        chk("t6_level", fifo_level, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_drop", drop_count, 0);
        chk("t6_overflow", overflow, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); mid();
            chk("t6_no_we", vram_we, 0);
        end

        // Flush with 5 entries queued and reads pending
        for (int i = 0; i < 5; i++) begin
            cyc();
            rd_req = 1; wr_en = 1;
            wr_addr = 16'h0400 + 16'(i); wr_data = 16'h4000 + 16'(i);
        end
        cyc(); wr_en = 0; flush_req = 1;
        mid();
        chk("t4_pre_grant", rd_grant, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(); flush_req = (i == 1);
            mid();
            chk("t4_no_grant", rd_grant, 0);
            chk_write("t4_flush", 16'h0400 + 16'(i), 16'h4000 + 16'(i));
            chk("t4_not_done", flush_done, 0);
        end
        cyc(); flush_req = 0; mid();
        chk("t4_done", flush_done, 1);
        chk("t4_resume", rd_grant, 1);
        cyc(); mid();
        chk("t4_done_pulse", flush_done, 0);

        // Flush requested on an empty queue completes on its own
        cyc(); rd_req = 0; flush_req = 1;
        cyc(); flush_req = 0;
        mid(); chk("t4e_pending", flush_done, 0);
        cyc(); mid(); chk("t4e_done", flush_done, 1);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
